// File: rtl/seq_div_6_by_4bit.sv
// Multi-cycle restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; results and div_by_zero hold until the next accepted start.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; results from the last operation held
// S_RUN  | iterating, cnt_q = 0..DW-1, one quotient bit per edge
// S_ZERO | divisor was 0; publish all-ones quotient and flag next edge
module seq_div_6_by_4bit #(
  parameter int DW = 6,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ZERO
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   rem_q, rem_d;
  logic [DW-1:0] quo_sh_q, quo_sh_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic [VW:0]   rem_shift;
  logic [VW:0]   rem_step;
  logic          q_bit;
  logic [DW-1:0] quo_step;

  // Partial remainder is always < divisor before the shift, so VW+1 bits never overflow.
  always_comb begin
    rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_step  = q_bit ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
    quo_step  = {quo_sh_q[DW-2:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_sh_d    = quo_sh_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d    = dividend;
          dvs_d    = divisor;
          rem_d    = '0;
          quo_sh_d = '0;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          state_d  = (divisor == '0) ? S_ZERO : S_RUN;
        end
      end
      S_RUN: begin
        dvd_d    = {dvd_q[DW-2:0], 1'b0};
        rem_d    = rem_step;
        quo_sh_d = quo_step;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          quotient_d  = quo_step;
          remainder_d = rem_step[VW-1:0];
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_ZERO: begin
        quotient_d  = '1;
        remainder_d = '0;
        dbz_d       = 1'b1;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_sh_q    <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_sh_q    <= quo_sh_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_6_by_4bit.sv
// Directed bench for seq_div_6_by_4bit: boundaries, divide-by-zero, busy protection,
// back-to-back, async reset mid-run, and a full sweep checked against the division identity.
module tb_seq_div_6_by_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int total;
  int bad;

  seq_div_6_by_4bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for done; operand inputs are scrambled after accept.
  task automatic run_op(input logic [5:0] a, input logic [3:0] b, input string tag,
                        input int exp_lat);
    int n;
    int nb;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = 6'($urandom);
    divisor  = 4'($urandom);
    n  = 0;
    nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busy"}, nb, exp_lat);
  endtask

  task automatic chk_res(input string tag, input int q, input int r, input int z);
    chk({tag, "_q"}, int'(quotient), q);
    chk({tag, "_r"}, int'(remainder), r);
    chk({tag, "_dbz"}, int'(div_by_zero), z);
  endtask

  initial begin
    int n;
    int dn;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_res("rst", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    run_op(6'd45, 4'd7, "nom", 6);
    chk_res("nom", 6, 3, 0);
    tick();
    chk("nom_done_pulse", int'(done), 0);
    chk("nom_busy_after", int'(busy), 0);
    chk("nom_hold_q", int'(quotient), 6);

    run_op(6'd63, 4'd1, "b63_1", 6);
    chk_res("b63_1", 63, 0, 0);
    run_op(6'd5, 4'd15, "b5_15", 6);
    chk_res("b5_15", 0, 5, 0);
    run_op(6'd0, 4'd9, "b0_9", 6);
    chk_res("b0_9", 0, 0, 0);
    run_op(6'd63, 4'd15, "b63_15", 6);
    chk_res("b63_15", 4, 3, 0);

    tick();
    run_op(6'd20, 4'd0, "dbz", 1);
    chk_res("dbz", 63, 0, 1);
    tick();
    chk("dbz_done_pulse", int'(done), 0);
    chk("dbz_hold", int'(div_by_zero), 1);
    run_op(6'd10, 4'd3, "dbz_next", 6);
    chk_res("dbz_next", 3, 1, 0);

    // Back-to-back: second start lands in the done cycle of the first.
    tick();
    run_op(6'd45, 4'd7, "b2b_a", 6);
    chk_res("b2b_a", 6, 3, 0);
    run_op(6'd50, 4'd6, "b2b_b", 6);
    chk_res("b2b_b", 8, 2, 0);

    // Busy protection: a second start three cycles in must be ignored.
    tick();
    start    = 1'b1;
    dividend = 6'd45;
    divisor  = 4'd7;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      if (n == 2) begin
        start    = 1'b1;
        dividend = 6'd10;
        divisor  = 4'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("busyp_lat", n, 6);
    chk_res("busyp", 6, 3, 0);
    dn = 0;
    repeat (10) begin
      tick();
      if (done) dn++;
    end
    chk("busyp_no_2nd_done", dn, 0);

    // Async reset between edges while running.
    start    = 1'b1;
    dividend = 6'd50;
    divisor  = 4'd6;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_done", int'(done), 0);
    chk_res("rstmid", 0, 0, 0);
    repeat (2) tick();
    #3 rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      tick();
      if (done) dn++;
    end
    chk("rstmid_no_done", dn, 0);
    run_op(6'd50, 4'd6, "after_rst", 6);
    chk_res("after_rst", 8, 2, 0);

    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(6'(a), 4'(b), "sweep", 6);
        chk("sweep_inv", int'(quotient) * b + int'(remainder), a);
        chk("sweep_rlt", (int'(remainder) < b) ? 1 : 0, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_div_6_by_4bit.md
Name: seq_div_6_by_4bit

Overview:
- Multi-cycle restoring divider; the inverse operation of the team's combinational array multipliers.
- Takes the 6-bit product width those multipliers produce as dividend and a 4-bit divisor; returns quotient and remainder.
- Used to recover operands or check products in the arithmetic datapath.
- Start/busy/done handshake, one quotient bit resolved per clock.

Parameters:
DW, 6, dividend and quotient width (iteration count)
VW, 4, divisor and remainder width

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk edge
dividend  input  DW  numerator, unsigned, captured on accepted start
divisor  input  VW  denominator, unsigned, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when results become valid
quotient  output  DW  unsigned quotient, held until next accepted start
remainder  output  VW  unsigned remainder, held until next accepted start
div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Interface:
  - One clock.
  - Reset is asynchronous and active-low: clk and rst_n.
- Reset:
  - rst_n low immediately forces state IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal shift and partial-remainder registers cleared.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating; iteration counter 0..DW-1.
- Accept:
  - start=1 at a rising edge while in IDLE.
  - Capture dividend and divisor.
  - Clear the quotient shift register and the partial remainder (VW+1 bits).
  - Load counter=0, enter RUN, busy=1 from that edge.
  - start while busy=1 is ignored; captured operands are unaffected.
- Iteration (each RUN edge):
  - Shift the next dividend bit, MSB first, into the LSB of the partial remainder.
  - If partial remainder >= divisor: subtract divisor and shift 1 into the quotient; otherwise shift 0.
  - Partial remainder is VW+1 bits wide so the compare never overflows.
- Completion:
  - On the edge that performs iteration DW-1:
    - Update quotient and remainder outputs.
    - done=1, busy=0, state returns to IDLE.
  - Latency: start accepted at edge k; done high and results valid after edge k+DW (6 cycles by default).
  - done is high for exactly one cycle.
- Divide by zero:
  - divisor==0 at accept skips RUN.
  - At the next edge: done=1, div_by_zero=1, quotient=all ones (63), remainder=0.
  - Latency 1 cycle.
- Result hold: quotient, remainder and div_by_zero are held until the next accepted start. On that start edge, div_by_zero is cleared.
- Back-to-back: start=1 in the cycle where done=1 is accepted, because the state is IDLE. The new operation begins with no idle gap.
- Reset mid-operation: the operation is abandoned, no done is produced, and all outputs return to reset values.
- Invariant (nonzero divisor): quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Nominal: dividend=45, divisor=7, start one cycle. Required: busy=1 for 6 cycles; then done pulse with quotient=6, remainder=3, div_by_zero=0.
- Boundaries:
  - 63/1 gives q=63, r=0.
  - 5/15 gives q=0, r=5.
  - 0/9 gives q=0, r=0.
  - 63/15 gives q=4, r=3.
  - Exhaustive sweep over all 64x15 nonzero-divisor pairs checks the invariant and 6-cycle latency.
- Divide by zero: dividend=20, divisor=0. Required: done one cycle after start, div_by_zero=1, quotient=63, remainder=0. The next valid division clears div_by_zero.
- Busy protection: start 45/7, then at cycle 3 drive start=1 with 10/3. Required: result still 6 r3 at cycle 6, and no second done.
- Back-to-back and reset:
  - Assert start with 50/6 in the done cycle of a previous op. Required: result q=8, r=2 exactly 6 cycles later.
  - Separately, pull rst_n low mid-RUN between clock edges. Required: all outputs 0 immediately, no done, and the next start works normally.
